// File: rtl/apb4_pkg.sv
`default_nettype none
// =============================================================================
// Module   : apb4_pkg
// Purpose  : Shared types and constants for the APB4 requester slice.
// Revision : 1.0 - initial release
// =============================================================================
package apb4_pkg;

    localparam int PROT_W     = 3;
    localparam int WAIT_CNT_W = 8;
    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                    write;
        logic [REQ_ADDR_W-1:0]   addr;
        logic [REQ_DATA_W-1:0]   wdata;
        logic [REQ_DATA_W/8-1:0] strb;
        logic [PROT_W-1:0]       prot;
    } apb_req_t;

endpackage
`default_nettype wire

// File: rtl/apb4_master_if.sv
`default_nettype none
// =============================================================================
// Module   : apb4_if
// Purpose  : APB4 bus signal bundle with requester and completer views.
// Revision : 1.0 - initial release
// =============================================================================
interface apb4_if
    import apb4_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_W-1:0]     PADDR;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W/8-1:0]   PSTRB;
    logic [PROT_W-1:0]     PPROT;
    logic                  PREADY;
    logic                  PSLVERR;
    logic [DATA_W-1:0]     PRDATA;

    modport master_drv_mp (
        output PSEL,
        output PENABLE,
        output PWRITE,
        output PADDR,
        output PWDATA,
        output PSTRB,
        output PPROT,
        input  PREADY,
        input  PSLVERR,
        input  PRDATA
    );

    modport slave_mp (
        input  PSEL,
        input  PENABLE,
        input  PWRITE,
        input  PADDR,
        input  PWDATA,
        input  PSTRB,
        input  PPROT,
        output PREADY,
        output PSLVERR,
        output PRDATA
    );

endinterface
`default_nettype wire

// File: rtl/apb4_wait_watchdog.sv
`default_nettype none
// =============================================================================
// Module   : apb4_wait_watchdog
// Purpose  : Saturating wait-state counter with a sticky over-limit flag.
// Revision : 1.0 - initial release
// =============================================================================
module apb4_wait_watchdog
    import apb4_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    input  wire logic inc_i,
    input  wire logic clr_i,
    output logic      wait_flag_o
);

    localparam logic [WAIT_CNT_W-1:0] c_LIMIT_M1 = WAIT_CNT_W'(WAIT_LIMIT - 1);
    localparam logic [WAIT_CNT_W-1:0] c_CNT_MAX  = {WAIT_CNT_W{1'b1}};

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;
    logic                  flag_q;
    logic                  flag_d;

    // Flag latches on the increment that reaches the limit and stays until cleared.
    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (clr_i) begin
            cnt_d  = '0;
            flag_d = 1'b0;
        end else if (inc_i) begin
            if (cnt_q == c_LIMIT_M1) begin
                flag_d = 1'b1;
            end
            if (cnt_q != c_CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign wait_flag_o = flag_q;

endmodule
`default_nettype wire

// File: rtl/apb4_master.sv
`default_nettype none
// =============================================================================
// Module   : apb4_master
// Purpose  : APB4 requester turning stimulus requests into SETUP/ACCESS cycles.
// Revision : 1.0 - initial release
// =============================================================================
module apb4_master
    import apb4_pkg::*;
#(
    parameter int ADDR_W     = REQ_ADDR_W,
    parameter int DATA_W     = REQ_DATA_W,
    parameter int WAIT_LIMIT = 16
) (
    input  wire logic                PCLK,
    input  wire logic                PRESETn,
    input  wire logic                transfer,
    input  wire logic                SWRITE,
    input  wire logic [ADDR_W-1:0]   SADDR,
    input  wire logic [DATA_W-1:0]   SWDATA,
    input  wire logic [DATA_W/8-1:0] SSTRB,
    input  wire logic [PROT_W-1:0]   SPROT,
    apb4_if.master_drv_mp            apb,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     err,
    output logic                     wait_flag
);

    localparam int STRB_W = DATA_W / 8;

    apb_state_e          state_q;
    apb_state_e          state_d;
    logic                psel_q;
    logic                psel_d;
    logic                penable_q;
    logic                penable_d;
    logic                pwrite_q;
    logic                pwrite_d;
    logic [ADDR_W-1:0]   paddr_q;
    logic [ADDR_W-1:0]   paddr_d;
    logic [DATA_W-1:0]   pwdata_q;
    logic [DATA_W-1:0]   pwdata_d;
    logic [STRB_W-1:0]   pstrb_q;
    logic [STRB_W-1:0]   pstrb_d;
    logic [PROT_W-1:0]   pprot_q;
    logic [PROT_W-1:0]   pprot_d;
    logic                done_q;
    logic                done_d;
    logic                err_q;
    logic                err_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   rd_data_d;

    logic                w_load;
    logic                w_access_wait;
    logic                w_complete;

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        done_d        = 1'b0;
        err_d         = err_q;
        rd_data_d     = rd_data_q;
        w_load        = 1'b0;
        w_access_wait = 1'b0;
        w_complete    = 1'b0;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    w_load    = 1'b1;
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    w_complete = 1'b1;
                    done_d     = 1'b1;
                    err_d      = apb.PSLVERR;
                    if (!pwrite_q) begin
                        rd_data_d = apb.PRDATA;
                    end
                    // A request waiting at completion chains straight into SETUP.
                    if (transfer) begin
                        w_load    = 1'b1;
                        state_d   = SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                    end else begin
                        state_d   = IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end else begin
                    w_access_wait = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // Address-phase fields only change on a capture; they hold through IDLE.
    always_comb begin
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        pprot_d  = pprot_q;
        if (w_load) begin
            pwrite_d = SWRITE;
            paddr_d  = SADDR;
            pwdata_d = SWDATA;
            pstrb_d  = SWRITE ? SSTRB : '0;
            pprot_d  = SPROT;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    apb4_wait_watchdog #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_watchdog (
        .clk_i       (PCLK),
        .rst_ni      (PRESETn),
        .inc_i       (w_access_wait),
        .clr_i       (w_complete),
        .wait_flag_o (wait_flag)
    );

    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PSTRB   = pstrb_q;
    assign apb.PPROT   = pprot_q;

    assign busy    = psel_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_apb4_master.sv
`default_nettype none
// =============================================================================
// Module   : tb_apb4_master
// Purpose  : Directed scoreboard bench for the APB4 requester.
// Revision : 1.0 - initial release
// =============================================================================
module tb_apb4_master;
    import apb4_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        transfer;
    logic        SWRITE;
    logic [31:0] SADDR;
    logic [31:0] SWDATA;
    logic [3:0]  SSTRB;
    logic [2:0]  SPROT;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;
    logic        err;
    logic        wait_flag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          waits;
        logic        err;
        logic [31:0] rdata;
    } slv_t;

    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    slv_t slv_q[$];
    exp_t exp_q[$];

    apb4_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

    apb4_master #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .WAIT_LIMIT (4)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .transfer  (transfer),
        .SWRITE    (SWRITE),
        .SADDR     (SADDR),
        .SWDATA    (SWDATA),
        .SSTRB     (SSTRB),
        .SPROT     (SPROT),
        .apb       (apb),
        .busy      (busy),
        .done      (done),
        .rd_data   (rd_data),
        .err       (err),
        .wait_flag (wait_flag)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p,
                         input int waits, input logic serr, input logic [31:0] prd);
        apb_req_t r;
        slv_t     sv;
        exp_t     ev;
        r = '{write: wr, addr: a, wdata: d, strb: s, prot: p};
        transfer = 1'b1;
        SWRITE   = r.write;
        SADDR    = r.addr;
        SWDATA   = r.wdata;
        SSTRB    = r.strb;
        SPROT    = r.prot;
        sv = '{waits: waits, err: serr, rdata: prd};
        ev = '{wr: wr, err: serr, rdata: prd};
        slv_q.push_back(sv);
        exp_q.push_back(ev);
    endtask

    // Completer model: inserts the queued number of wait states, with junk on
    // PSLVERR/PRDATA while not ready.
    initial begin
        slv_t cur;
        int   cnt;
        cur = '{waits: 0, err: 1'b0, rdata: 32'h0};
        cnt = 0;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        apb.PRDATA  = 32'h0;
        forever begin
            @(negedge PCLK);
            if (apb.PSEL && !apb.PENABLE) begin
                if (slv_q.size() > 0) cur = slv_q.pop_front();
                else cur = '{waits: 0, err: 1'b0, rdata: 32'h0};
                cnt = 0;
                apb.PREADY  = 1'b0;
                apb.PSLVERR = 1'b0;
            end else if (apb.PSEL && apb.PENABLE) begin
                if (cnt >= cur.waits) begin
                    apb.PREADY  = 1'b1;
                    apb.PSLVERR = cur.err;
                    apb.PRDATA  = cur.rdata;
                end else begin
                    apb.PREADY  = 1'b0;
                    apb.PSLVERR = 1'b1;
                    apb.PRDATA  = $urandom;
                end
                cnt++;
            end else begin
                apb.PREADY  = 1'b0;
                apb.PSLVERR = 1'b0;
            end
        end
    end

    // Monitor: every done pulse pops one expectation.
    initial begin
        logic [31:0] last_rd;
        exp_t        e;
        last_rd = 32'h0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) last_rd = 32'h0;
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: got done=1 want no pending transfer");
                end else begin
                    e = exp_q.pop_front();
                    chk("done_err", err, e.err);
                    if (!e.wr) last_rd = e.rdata;
                    chk("done_rd_data", rd_data, last_rd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        transfer = 1'b0;
        SWRITE   = 1'b0;
        SADDR    = '0;
        SWDATA   = '0;
        SSTRB    = '0;
        SPROT    = '0;
        PRESETn  = 1'b0;
        tick;
        tick;
        chk("rst_psel", apb.PSEL, 0);
        chk("rst_penable", apb.PENABLE, 0);
        chk("rst_paddr", apb.PADDR, 0);
        chk("rst_pstrb", apb.PSTRB, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wait_flag", wait_flag, 0);
        PRESETn = 1'b1;
        tick;

        // Single write, no waits
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010, 0, 1'b0, 32'h0);
        tick;
        transfer = 1'b0;
        chk("wr_c1_psel", apb.PSEL, 1);
        chk("wr_c1_penable", apb.PENABLE, 0);
        chk("wr_c1_paddr", apb.PADDR, 32'h10);
        chk("wr_c1_pwdata", apb.PWDATA, 32'hDEADBEEF);
        chk("wr_c1_pstrb", apb.PSTRB, 4'hF);
        chk("wr_c1_pwrite", apb.PWRITE, 1);
        chk("wr_c1_pprot", apb.PPROT, 3'b010);
        tick;
        chk("wr_c2_penable", apb.PENABLE, 1);
        chk("wr_c2_done", done, 0);
        tick;
        chk("wr_c3_done", done, 1);
        chk("wr_c3_psel", apb.PSEL, 0);
        chk("wr_c3_busy", busy, 0);
        tick;
        chk("wr_done_pulse", done, 0);
        chk("wr_paddr_hold", apb.PADDR, 32'h10);
        chk("wr_pstrb_hold", apb.PSTRB, 4'hF);

        // Read with three wait states
        issue(1'b0, 32'h20, 32'h55AA55AA, 4'hF, 3'b000, 3, 1'b0, 32'h12345678);
        tick;
        transfer = 1'b0;
        chk("rd_pstrb_setup", apb.PSTRB, 0);
        chk("rd_pwrite", apb.PWRITE, 0);
        for (int i = 1; i <= 4; i++) begin
            tick;
            chk("rd_acc_penable", apb.PENABLE, 1);
            chk("rd_acc_paddr", apb.PADDR, 32'h20);
            chk("rd_acc_pstrb", apb.PSTRB, 0);
            chk("rd_acc_done", done, 0);
            chk("rd_acc_wait_flag", wait_flag, 0);
        end
        tick;
        chk("rd_done", done, 1);
        chk("rd_data", rd_data, 32'h12345678);
        tick;

        // Back-to-back write then read
        issue(1'b1, 32'h4, 32'hA5A50004, 4'h3, 3'b001, 0, 1'b0, 32'h0);
        tick;
        chk("b2b_w_psel", apb.PSEL, 1);
        chk("b2b_w_pen0", apb.PENABLE, 0);
        issue(1'b0, 32'h8, 32'h0, 4'hF, 3'b000, 0, 1'b0, 32'hCAFEF00D);
        tick;
        chk("b2b_w_psel_acc", apb.PSEL, 1);
        chk("b2b_w_pen1", apb.PENABLE, 1);
        chk("b2b_w_paddr", apb.PADDR, 32'h4);
        chk("b2b_w_pstrb", apb.PSTRB, 4'h3);
        tick;
        transfer = 1'b0;
        chk("b2b_r_psel", apb.PSEL, 1);
        chk("b2b_r_pen0", apb.PENABLE, 0);
        chk("b2b_r_paddr", apb.PADDR, 32'h8);
        chk("b2b_r_pstrb", apb.PSTRB, 0);
        chk("b2b_w_done", done, 1);
        tick;
        chk("b2b_r_psel_acc", apb.PSEL, 1);
        chk("b2b_r_pen1", apb.PENABLE, 1);
        chk("b2b_r_nodone", done, 0);
        tick;
        chk("b2b_r_done", done, 1);
        chk("b2b_r_idle", apb.PSEL, 0);
        chk("b2b_r_data", rd_data, 32'hCAFEF00D);
        tick;

        // Slave error on a write, then cleared by a good read
        issue(1'b1, 32'hFFC, 32'h01020304, 4'hF, 3'b000, 0, 1'b1, 32'h0);
        tick;
        transfer = 1'b0;
        tick;
        tick;
        chk("serr_done", done, 1);
        chk("serr_err", err, 1);
        chk("serr_rd_hold", rd_data, 32'hCAFEF00D);
        tick;
        tick;
        chk("serr_err_hold", err, 1);
        chk("serr_done_low", done, 0);
        issue(1'b0, 32'h100, 32'h0, 4'hF, 3'b000, 1, 1'b0, 32'h0BADF00D);
        tick;
        transfer = 1'b0;
        tick;
        tick;
        chk("serr_mid_err_hold", err, 1);
        tick;
        chk("serr_clr_done", done, 1);
        chk("serr_clr_err", err, 0);
        chk("serr_clr_rd", rd_data, 32'h0BADF00D);
        tick;

        // Watchdog: six wait states against a limit of four
        issue(1'b1, 32'h30, 32'h11112222, 4'hC, 3'b000, 6, 1'b0, 32'h0);
        tick;
        transfer = 1'b0;
        tick;
        for (int k = 1; k <= 7; k++) begin
            chk("wdog_flag", wait_flag, (k >= 5) ? 1 : 0);
            chk("wdog_access", apb.PSEL && apb.PENABLE, 1);
            chk("wdog_paddr", apb.PADDR, 32'h30);
            tick;
        end
        chk("wdog_done", done, 1);
        chk("wdog_flag_clr", wait_flag, 0);
        tick;

        // Reset during a wait state
        issue(1'b0, 32'h40, 32'h0, 4'hF, 3'b000, 5, 1'b0, 32'hFEEDFACE);
        tick;
        transfer = 1'b0;
        tick;
        tick;
        chk("mrst_busy_before", busy, 1);
        PRESETn = 1'b0;
        tick;
        exp_q.delete();
        chk("mrst_psel", apb.PSEL, 0);
        chk("mrst_penable", apb.PENABLE, 0);
        chk("mrst_paddr", apb.PADDR, 0);
        chk("mrst_pwdata", apb.PWDATA, 0);
        chk("mrst_pstrb", apb.PSTRB, 0);
        chk("mrst_pprot", apb.PPROT, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_err", err, 0);
        chk("mrst_rd_data", rd_data, 0);
        chk("mrst_wait_flag", wait_flag, 0);
        tick;
        PRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("mrst_no_done", done, 0);
        end
        issue(1'b1, 32'h44, 32'h77778888, 4'hF, 3'b111, 0, 1'b0, 32'h0);
        tick;
        transfer = 1'b0;
        chk("post_rst_psel", apb.PSEL, 1);
        tick;
        tick;
        chk("post_rst_done", done, 1);
        chk("post_rst_paddr", apb.PADDR, 32'h44);
        tick;
        tick;

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
